// File: rtl/nanomamba_sf_router_pl.sv
// Spectral-flatness MoE router: log2-domain flatness, restoring divide, PWL gate, hysteresis.
// Optional gate EMA smoothing is compiled in with `define NANOMAMBA_ROUTER_GATE_SMOOTH_EN.
module nanomamba_sf_router_pl #(
    parameter int N_MELS      = 40,
    parameter int MEL_W       = 16,
    parameter int ALPHA_SHIFT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [MEL_W-1:0] mel_in,
    input  logic             mel_valid,
    input  logic             mel_last,
    output logic             mel_ready,
    input  logic [7:0]       cfg_temp,
    input  logic [6:0]       cfg_thresh,
    input  logic [7:0]       cfg_hi,
    input  logic [7:0]       cfg_lo,
    output logic [7:0]       gate_out,
    output logic             gate_valid,
    output logic             expert_sel,
    output logic             frame_err
);

    localparam int CW   = $clog2(N_MELS + 1);
    localparam int LS_W = 7 + CW;
    localparam int AS_W = MEL_W + CW;
    localparam int DW   = (LS_W > AS_W) ? LS_W : AS_W;
    localparam int KW   = $clog2(DW + 1);

    localparam logic [CW:0]   DIV_D   = (CW + 1)'(N_MELS);
    localparam logic [5:0]    N_CNT   = 6'(N_MELS);
    localparam logic [5:0]    CNT_MAX = 6'd63;
    localparam logic [KW-1:0] L_LAST  = KW'(LS_W - 1);
    localparam logic [KW-1:0] A_LAST  = KW'(AS_W - 1);

    localparam logic [2:0] S_ACC  = 3'd0;
    localparam logic [2:0] S_CHK  = 3'd1;
    localparam logic [2:0] S_DIVL = 3'd2;
    localparam logic [2:0] S_DIVA = 3'd3;
    localparam logic [2:0] S_GATE = 3'd4;
    localparam logic [2:0] S_OUT  = 3'd5;

    if (N_MELS < 2 || N_MELS > 63 || MEL_W < 1 || MEL_W > 16 ||
        ALPHA_SHIFT < 0 || ALPHA_SHIFT > 8) begin : g_param_check
        $error("nanomamba_sf_router_pl: parameter out of range");
    end

    // Q4.3 log2: MSB index in the integer part, next three bits as fraction
    function automatic logic [6:0] log2q(input logic [MEL_W-1:0] x);
        logic [MEL_W+2:0] t;
        logic [6:0]       p;
        logic [2:0]       f;
        p = '0;
        for (int i = 0; i < MEL_W; i++) begin
            if (x[i]) p = 7'(i);
        end
        t = {x, 3'b000};
        f = 3'(t >> p);
        if (x == '0) return 7'd0;
        return (p << 3) | {4'd0, f};
    endfunction

    logic [2:0]      state;
    logic [LS_W-1:0] log_sum;
    logic [AS_W-1:0] arith_sum;
    logic [5:0]      count;
    logic [DW-1:0]   div_q;
    logic [CW-1:0]   div_r;
    logic [KW-1:0]   div_cnt;
    logic [LS_W-1:0] mean_log;
    logic [7:0]      temp_r;
    logic [6:0]      thresh_r;
    logic [7:0]      hi_r;
    logic [7:0]      lo_r;
    logic [7:0]      g_r;

    assign mel_ready = (state == S_ACC);

    logic [6:0] l2_in;
    assign l2_in = log2q(mel_in);

    logic [CW:0]   rr;
    logic          q_bit;
    logic [CW-1:0] r_nxt;
    logic [DW-1:0] q_nxt;

    always_comb begin
        rr    = {div_r, div_q[DW-1]};
        q_bit = (rr >= DIV_D);
        r_nxt = q_bit ? CW'(rr - DIV_D) : rr[CW-1:0];
        q_nxt = {div_q[DW-2:0], q_bit};
    end

    // After DIV_A the quotient (am) sits in the low bits of div_q
    logic [6:0]               l2_am;
    logic signed [LS_W+1:0]   dd;
    logic [6:0]               d;
    logic signed [8:0]        xs;
    logic signed [17:0]       prod;
    logic signed [17:0]       gw;
    logic [7:0]               g_c;

    always_comb begin
        l2_am = log2q(div_q[MEL_W-1:0]);
        dd    = $signed((LS_W + 2)'(l2_am)) - $signed((LS_W + 2)'(mean_log));
        d     = 7'd0;
        if (dd[LS_W+1])
            d = 7'd0;
        else if (dd > $signed((LS_W + 2)'(127)))
            d = 7'd127;
        else
            d = dd[6:0];
        xs   = $signed({2'b00, thresh_r}) - $signed({2'b00, d});
        prod = xs * $signed({1'b0, temp_r});
        gw   = 18'sd128 + (prod >>> 4);
        g_c  = 8'd0;
        if (gw < 0)
            g_c = 8'd0;
        else if (gw > 18'sd255)
            g_c = 8'd255;
        else
            g_c = gw[7:0];
    end

    logic [7:0] g_fin;

`ifdef NANOMAMBA_ROUTER_GATE_SMOOTH_EN
    logic [7:0]        gate_s;
    logic signed [9:0] sd;
    logic signed [9:0] s_sum;

    assign sd    = $signed({2'b00, g_r}) - $signed({2'b00, gate_s});
    assign s_sum = $signed({2'b00, gate_s}) + (sd >>> ALPHA_SHIFT);
    assign g_fin = 8'(s_sum);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            gate_s <= 8'd128;
        else if (state == S_OUT)
            gate_s <= g_fin;
    end
`else
    assign g_fin = g_r;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_ACC;
            log_sum    <= '0;
            arith_sum  <= '0;
            count      <= '0;
            div_q      <= '0;
            div_r      <= '0;
            div_cnt    <= '0;
            mean_log   <= '0;
            temp_r     <= '0;
            thresh_r   <= '0;
            hi_r       <= '0;
            lo_r       <= '0;
            g_r        <= 8'd128;
            gate_out   <= 8'd128;
            gate_valid <= 1'b0;
            expert_sel <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            gate_valid <= 1'b0;
            frame_err  <= 1'b0;
            unique case (state)
                S_ACC: begin
                    if (mel_valid) begin
                        log_sum   <= log_sum + LS_W'(l2_in);
                        arith_sum <= arith_sum + AS_W'(mel_in);
                        if (count != CNT_MAX) count <= count + 6'd1;
                        if (mel_last) state <= S_CHK;
                    end
                end
                S_CHK: begin
                    if (count != N_CNT) begin
                        frame_err <= 1'b1;
                        log_sum   <= '0;
                        arith_sum <= '0;
                        count     <= '0;
                        state     <= S_ACC;
                    end else begin
                        temp_r   <= cfg_temp;
                        thresh_r <= cfg_thresh;
                        hi_r     <= cfg_hi;
                        lo_r     <= cfg_lo;
                        div_q    <= DW'(log_sum) << (DW - LS_W);
                        div_r    <= '0;
                        div_cnt  <= '0;
                        state    <= S_DIVL;
                    end
                end
                S_DIVL: begin
                    div_q   <= q_nxt;
                    div_r   <= r_nxt;
                    div_cnt <= div_cnt + 1'b1;
                    if (div_cnt == L_LAST) begin
                        mean_log <= q_nxt[LS_W-1:0];
                        div_q    <= DW'(arith_sum) << (DW - AS_W);
                        div_r    <= '0;
                        div_cnt  <= '0;
                        state    <= S_DIVA;
                    end
                end
                S_DIVA: begin
                    div_q   <= q_nxt;
                    div_r   <= r_nxt;
                    div_cnt <= div_cnt + 1'b1;
                    if (div_cnt == A_LAST) state <= S_GATE;
                end
                S_GATE: begin
                    g_r   <= g_c;
                    state <= S_OUT;
                end
                S_OUT: begin
                    gate_out   <= g_fin;
                    gate_valid <= 1'b1;
                    if (g_fin >= hi_r)
                        expert_sel <= 1'b1;
                    else if (g_fin <= lo_r)
                        expert_sel <= 1'b0;
                    log_sum   <= '0;
                    arith_sum <= '0;
                    count     <= '0;
                    state     <= S_ACC;
                end
                default: state <= S_ACC;
            endcase
        end
    end

endmodule

// File: tb/tb_nanomamba_sf_router_pl.sv
// Directed self-checking bench for nanomamba_sf_router_pl (default build, no smoothing).
// Frames: flat 0x1000, peaky 39x0x0001 + 0xFFFF, all-zero.
module tb_nanomamba_sf_router_pl;

    logic        clk;
    logic        rst_n;
    logic [15:0] mel_in;
    logic        mel_valid;
    logic        mel_last;
    logic        mel_ready;
    logic [7:0]  cfg_temp;
    logic [6:0]  cfg_thresh;
    logic [7:0]  cfg_hi;
    logic [7:0]  cfg_lo;
    logic [7:0]  gate_out;
    logic        gate_valid;
    logic        expert_sel;
    logic        frame_err;

    int checks = 0;
    int errors = 0;

    nanomamba_sf_router_pl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mel_in     (mel_in),
        .mel_valid  (mel_valid),
        .mel_last   (mel_last),
        .mel_ready  (mel_ready),
        .cfg_temp   (cfg_temp),
        .cfg_thresh (cfg_thresh),
        .cfg_hi     (cfg_hi),
        .cfg_lo     (cfg_lo),
        .gate_out   (gate_out),
        .gate_valid (gate_valid),
        .expert_sel (expert_sel),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_cfg(input logic [7:0] t, input logic [6:0] th,
                             input logic [7:0] hi, input logic [7:0] lo);
        cfg_temp   = t;
        cfg_thresh = th;
        cfg_hi     = hi;
        cfg_lo     = lo;
    endtask

    // kind 0 = flat, 1 = peaky, 2 = zeros; mel_last on bin n
    task automatic send_frame(input int kind, input int n);
        for (int i = 0; i < n; i++) begin
            case (kind)
                0: mel_in = 16'h1000;
                1: mel_in = (i == n - 1) ? 16'hFFFF : 16'h0001;
                default: mel_in = 16'h0000;
            endcase
            mel_valid = 1'b1;
            mel_last  = (i == n - 1);
            @(posedge clk); #1;
        end
        mel_valid = 1'b0;
        mel_last  = 1'b0;
        mel_in    = 16'h0000;
    endtask

    // Cycles from the last handshake edge to gate_valid; -1 on timeout
    task automatic wait_gate(input int hold, input int chg_temp, output int lat);
        lat = -1;
        mel_valid = (hold > 0);
        mel_in    = (hold > 0) ? 16'hFFFF : 16'h0000;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk); #1;
            if (c == 1 && chg_temp >= 0) cfg_temp = 8'(chg_temp);
            if (hold > 0 && c == 20) begin
                checks++;
                if (mel_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_ready: got %0b expected 0", mel_ready);
                end
            end
            if (c >= hold) mel_valid = 1'b0;
            if (gate_valid === 1'b1) begin
                lat = c;
                break;
            end
        end
        mel_valid = 1'b0;
        mel_in    = 16'h0000;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mel_in = '0; mel_valid = 1'b0; mel_last = 1'b0;
        apply_cfg(8'h80, 7'd8, 8'd160, 8'd96);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (gate_out !== 8'd128) begin
            errors++; $display("FAIL reset_gate: got %0d expected 128", gate_out);
        end
        checks++;
        if ({gate_valid, expert_sel, frame_err} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 000",
                     {gate_valid, expert_sel, frame_err});
        end
        checks++;
        if (mel_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %0b expected 1", mel_ready);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_flat();
        int lat;
        apply_cfg(8'h80, 7'd8, 8'd160, 8'd96);
        send_frame(0, 40);
        checks++;
        if (mel_ready !== 1'b0) begin
            errors++; $display("FAIL flat_ready_drop: got %0b expected 0", mel_ready);
        end
        wait_gate(0, -1, lat);
        checks++;
        if (lat !== 38) begin
            errors++; $display("FAIL flat_latency: got %0d expected 38", lat);
        end
        checks++;
        if (gate_out !== 8'd192) begin
            errors++; $display("FAIL flat_gate: got %0d expected 192", gate_out);
        end
        checks++;
        if (expert_sel !== 1'b1) begin
            errors++; $display("FAIL flat_sel: got %0b expected 1", expert_sel);
        end
        @(posedge clk); #1;
        checks++;
        if ({gate_valid, mel_ready} !== 2'b01) begin
            errors++;
            $display("FAIL flat_pulse_end: got %b expected 01", {gate_valid, mel_ready});
        end
    endtask

    task automatic test_short();
        int errs_seen = 0;
        int gv_seen = 0;
        apply_cfg(8'h80, 7'd8, 8'd160, 8'd96);
        send_frame(0, 10);
        checks++;
        if (mel_ready !== 1'b0) begin
            errors++; $display("FAIL short_chk_ready: got %0b expected 0", mel_ready);
        end
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #1;
            if (frame_err === 1'b1) begin
                errs_seen++;
                checks++;
                if (mel_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL short_ready: got %0b expected 1", mel_ready);
                end
            end
            if (gate_valid === 1'b1) gv_seen++;
        end
        checks++;
        if (errs_seen !== 1) begin
            errors++; $display("FAIL short_err_pulses: got %0d expected 1", errs_seen);
        end
        checks++;
        if (gv_seen !== 0) begin
            errors++; $display("FAIL short_gate_valid: got %0d expected 0", gv_seen);
        end
        checks++;
        if ({gate_out, expert_sel} !== {8'd192, 1'b1}) begin
            errors++;
            $display("FAIL short_hold: got %0d/%0b expected 192/1", gate_out, expert_sel);
        end
    endtask

    task automatic test_peaky();
        int lat;
        apply_cfg(8'h80, 7'd8, 8'd160, 8'd96);
        send_frame(1, 40);
        wait_gate(0, -1, lat);
        checks++;
        if (lat !== 38) begin
            errors++; $display("FAIL peaky_latency: got %0d expected 38", lat);
        end
        checks++;
        if (gate_out !== 8'd0) begin
            errors++; $display("FAIL peaky_gate: got %0d expected 0", gate_out);
        end
        checks++;
        if (expert_sel !== 1'b0) begin
            errors++; $display("FAIL peaky_sel: got %0b expected 0", expert_sel);
        end
    endtask

    task automatic test_hysteresis();
        int kind_t[8] = '{0, 0, 1, 0, 0, 1, 0, 1};
        int temp_t[8] = '{8'h80, 8'h18, 8'h10, 8'h18, 8'h80, 8'h18, 8'hFF, 8'h10};
        int thr_t[8]  = '{8, 8, 43, 8, 8, 80, 127, 43};
        int hi_t[8]   = '{160, 160, 160, 160, 192, 160, 160, 160};
        int lo_t[8]   = '{96, 96, 96, 96, 96, 96, 96, 90};
        int g_t[8]    = '{192, 140, 90, 140, 192, 126, 255, 90};
        int sel_t[8]  = '{1, 1, 0, 0, 1, 1, 1, 0};
        int lat;
        for (int k = 0; k < 8; k++) begin
            apply_cfg(8'(temp_t[k]), 7'(thr_t[k]), 8'(hi_t[k]), 8'(lo_t[k]));
            send_frame(kind_t[k], 40);
            wait_gate(0, -1, lat);
            checks++;
            if (gate_out !== 8'(g_t[k])) begin
                errors++;
                $display("FAIL hyst_gate[%0d]: got %0d expected %0d", k, gate_out, g_t[k]);
            end
            checks++;
            if (expert_sel !== 1'(sel_t[k])) begin
                errors++;
                $display("FAIL hyst_sel[%0d]: got %0b expected %0d", k, expert_sel, sel_t[k]);
            end
        end
    endtask

    task automatic test_zero();
        int lat;
        apply_cfg(8'h80, 7'd8, 8'd160, 8'd96);
        send_frame(2, 40);
        wait_gate(0, -1, lat);
        checks++;
        if ({gate_out, expert_sel} !== {8'd192, 1'b1} || lat !== 38) begin
            errors++;
            $display("FAIL zero_frame: got %0d/%0b lat %0d expected 192/1 lat 38",
                     gate_out, expert_sel, lat);
        end
    endtask

    task automatic test_cfg_latch();
        int lat;
        apply_cfg(8'h80, 7'd8, 8'd160, 8'd96);
        send_frame(0, 40);
        wait_gate(0, 8'h18, lat);
        checks++;
        if (gate_out !== 8'd192) begin
            errors++; $display("FAIL cfg_latch: got %0d expected 192", gate_out);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        apply_cfg(8'h80, 7'd8, 8'd160, 8'd96);
        send_frame(0, 40);
        wait_gate(30, -1, lat);
        checks++;
        if (gate_out !== 8'd192 || lat !== 38) begin
            errors++;
            $display("FAIL backpressure: got %0d lat %0d expected 192 lat 38", gate_out, lat);
        end
        apply_cfg(8'h80, 7'd8, 8'd160, 8'd96);
        send_frame(0, 40);
        wait_gate(0, -1, lat);
        checks++;
        if (gate_out !== 8'd192) begin
            errors++; $display("FAIL post_backpressure: got %0d expected 192", gate_out);
        end
    endtask

    task automatic test_reset_mid();
        int gv_seen = 0;
        int lat;
        apply_cfg(8'h80, 7'd8, 8'd160, 8'd96);
        send_frame(0, 40);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        checks++;
        if ({gate_out, gate_valid, expert_sel, frame_err, mel_ready} !==
            {8'd128, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL mid_reset: got %0d %b expected 128 0001", gate_out,
                     {gate_valid, expert_sel, frame_err, mel_ready});
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 45; c++) begin
            @(posedge clk); #1;
            if (gate_valid === 1'b1 || frame_err === 1'b1) gv_seen++;
        end
        checks++;
        if (gv_seen !== 0) begin
            errors++; $display("FAIL mid_reset_quiet: got %0d expected 0", gv_seen);
        end
        send_frame(0, 40);
        wait_gate(0, -1, lat);
        checks++;
        if ({gate_out, expert_sel} !== {8'd192, 1'b1} || lat !== 38) begin
            errors++;
            $display("FAIL after_reset: got %0d/%0b lat %0d expected 192/1 lat 38",
                     gate_out, expert_sel, lat);
        end
    endtask

    initial begin
        test_reset();
        test_flat();
        test_short();
        test_peaky();
        test_hysteresis();
        test_zero();
        test_cfg_latch();
        test_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
